bg_char_pixel_fetch: RTL

Background-pipeline stage that sits directly downstream of the character-data address lookup. It accepts one tile-pixel request per handshake: a VRAM byte address, the sub-byte pixel selector, the palette mode and the 4-bit palette bank. It issues halfword reads to the VRAM arbiter and extracts the 4bpp or 8bpp pixel from the returned halfword. Results are buffered as palette-RAM indices with a transparency flag, in request order, for the BG priority/mixing stage.

---
 rtl/bg_char_pixel_fetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bg_char_pixel_fetch.sv
// BG char pixel fetch: VRAM halfword read + 4bpp/8bpp palette-index extraction, in request order; BG_FETCH_CACHE_EN adds a one-halfword cache.
// Latency grant wait + read latency + 2; in_ready drops when OUT_DEPTH credits or MAX_OUTSTANDING read slots are used up.
module bg_char_pixel_fetch #(
  parameter int OUT_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] in_addr,
  input  logic        in_xsel,
  input  logic [3:0]  in_pal_bank,
  input  logic        in_palettemode,
  output logic        vram_req,
  output logic [15:0] vram_addr,
  input  logic        vram_gnt,
  input  logic        vram_rvalid,
  input  logic [15:0] vram_rdata,
  input  logic        vram_inval,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_index,
  output logic        out_transparent
);

  typedef struct packed {
    logic [15:0] haddr;
    logic        bsel;
    logic        xsel;
    logic [3:0]  bank;
    logic        mode;
  } side_t;

  localparam int CW = $clog2(OUT_DEPTH + MAX_OUTSTANDING + 4);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FW = $clog2(OUT_DEPTH);

  side_t         r_req;
  logic          r_req_full;
  logic          r_live;
  side_t         r_q [MAX_OUTSTANDING];
  logic [QW-1:0] r_q_wp, r_q_rp;
  logic [CW-1:0] r_outst;
  logic          r_ext_vld;
  logic [8:0]    r_ext_dat;
  logic [8:0]    r_fifo [OUT_DEPTH];
  logic [FW-1:0] r_f_wp, r_f_rp;
  logic [CW-1:0] r_f_cnt;

  side_t         w_in_side, w_q_head;
  logic          w_gnt, w_pop, w_fire_in, w_fire_out, w_hit;
  logic [15:0]   w_hit_data;
  logic [CW-1:0] w_used, w_outst_nxt;

  // Result packed as {transparent, index}.
  function automatic logic [8:0] extract(input side_t s, input logic [15:0] hw);
    logic [7:0] b;
    logic [3:0] nib;
    b   = s.bsel ? hw[15:8] : hw[7:0];
    nib = s.xsel ? b[7:4] : b[3:0];
    return s.mode ? {b == 8'd0, b} : {nib == 4'd0, s.bank, nib};
  endfunction

  function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  function automatic logic [FW-1:0] f_next(input logic [FW-1:0] p);
    return (p == FW'(OUT_DEPTH - 1)) ? '0 : p + FW'(1);
  endfunction

  assign w_in_side   = {in_addr[16:1], in_addr[0], in_xsel, in_pal_bank, in_palettemode};
  assign w_q_head    = r_q[r_q_rp];
  assign w_gnt       = r_req_full && vram_gnt;
  assign w_pop       = vram_rvalid && (r_outst != '0);
  assign w_fire_out  = out_valid && out_ready;
  assign w_fire_in   = in_valid && in_ready;
  // Credits cover every pixel from acceptance until the consumer takes it.
  assign w_used      = r_outst + CW'(r_ext_vld) + r_f_cnt + CW'(r_req_full) - CW'(w_fire_out);
  assign w_outst_nxt = r_outst + CW'(w_gnt) - CW'(w_pop);
  assign in_ready    = r_live && (!r_req_full || vram_gnt) &&
                       (w_used < CW'(OUT_DEPTH)) && (w_outst_nxt < CW'(MAX_OUTSTANDING));

  assign vram_req        = r_req_full;
  assign vram_addr       = r_req.haddr;
  assign out_valid       = (r_f_cnt != '0);
  assign out_index       = out_valid ? r_fifo[r_f_rp][7:0] : 8'd0;
  assign out_transparent = out_valid && r_fifo[r_f_rp][8];

`ifdef BG_FETCH_CACHE_EN
  logic        r_c_vld;
  logic [15:0] r_c_addr, r_c_data;

  // A hit may only bypass VRAM when nothing older is still waiting on it.
  assign w_hit      = r_c_vld && !vram_inval && (r_c_addr == in_addr[16:1]) &&
                      (r_outst == '0) && !r_req_full;
  assign w_hit_data = r_c_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_c_vld  <= 1'b0;
      r_c_addr <= '0;
      r_c_data <= '0;
    end else if (vram_inval) begin
      r_c_vld <= 1'b0;
    end else if (w_pop) begin
      r_c_vld  <= 1'b1;
      r_c_addr <= w_q_head.haddr;
      r_c_data <= vram_rdata;
    end
  end
`else
  logic w_unused;
  assign w_hit      = 1'b0;
  assign w_hit_data = 16'h0;
  assign w_unused   = ^{vram_inval, w_q_head.haddr};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_live     <= 1'b0;
      r_req      <= '0;
      r_req_full <= 1'b0;
      r_q_wp     <= '0;
      r_q_rp     <= '0;
      r_outst    <= '0;
      r_ext_vld  <= 1'b0;
      r_ext_dat  <= '0;
      r_f_wp     <= '0;
      r_f_rp     <= '0;
      r_f_cnt    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_fire_in && !w_hit) begin
        r_req_full <= 1'b1;
        r_req      <= w_in_side;
      end else if (w_gnt) begin
        r_req_full <= 1'b0;
      end
      if (w_gnt) r_q_wp <= q_next(r_q_wp);
      if (w_pop) r_q_rp <= q_next(r_q_rp);
      r_outst <= w_outst_nxt;

      r_ext_vld <= w_pop || (w_fire_in && w_hit);
      if (w_pop) r_ext_dat <= extract(w_q_head, vram_rdata);
      else if (w_fire_in && w_hit) r_ext_dat <= extract(w_in_side, w_hit_data);

      if (r_ext_vld) r_f_wp <= f_next(r_f_wp);
      if (w_fire_out) r_f_rp <= f_next(r_f_rp);
      r_f_cnt <= r_f_cnt + CW'(r_ext_vld) - CW'(w_fire_out);
    end
  end

  always_ff @(posedge clock) begin
    if (w_gnt) r_q[r_q_wp] <= r_req;
    if (r_ext_vld) r_fifo[r_f_wp] <= r_ext_dat;
  end

endmodule
